// File: rtl/reorder_buffer.sv
// Reorder buffer: entries are allocated in program order, complete out of order on the writeback
// ports, and retire in order (up to COMMIT_WIDTH per cycle); an excepting head entry flushes all.
module reorder_buffer #(
  parameter int unsigned ROB_ENTRIES  = 16,
  parameter int unsigned NUM_PREGS    = 64,
  parameter int unsigned NUM_AREGS    = 32,
  parameter int unsigned WB_PORTS     = 2,
  parameter int unsigned COMMIT_WIDTH = 2,
  localparam int unsigned IW = $clog2(ROB_ENTRIES),
  localparam int unsigned PW = $clog2(NUM_PREGS),
  localparam int unsigned AW = $clog2(NUM_AREGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  output logic [IW-1:0]              alloc_idx,
  input  logic                       alloc_has_dest,
  input  logic [AW-1:0]              alloc_areg,
  input  logic [PW-1:0]              alloc_preg,
  input  logic [PW-1:0]              alloc_old_preg,
  input  logic                       alloc_mbegin,
  input  logic                       alloc_mend,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*IW-1:0]     wb_idx,
  input  logic [WB_PORTS-1:0]        wb_exc,
  output logic [COMMIT_WIDTH-1:0]    commit_valid,
  output logic [COMMIT_WIDTH-1:0]    commit_has_dest,
  output logic [COMMIT_WIDTH*AW-1:0] commit_areg,
  output logic [COMMIT_WIDTH*PW-1:0] commit_preg,
  output logic [COMMIT_WIDTH*PW-1:0] commit_free_preg,
  output logic                       flush,
  output logic                       irq_ok,
  output logic [IW:0]                count
);

  typedef logic [IW:0]   ptr_t;
  typedef logic [IW-1:0] idx_t;

  // Control state
  logic [ROB_ENTRIES-1:0] valid_q;
  logic [ROB_ENTRIES-1:0] busy_q;
  logic [ROB_ENTRIES-1:0] exc_q;
  ptr_t                   head_q;
  ptr_t                   tail_q;
  ptr_t                   count_q;
  logic                   last_mend_q;

  // Payload state, only meaningful while the matching valid bit is set
  logic [ROB_ENTRIES-1:0] has_dest_q;
  logic [ROB_ENTRIES-1:0] mbegin_q;
  logic [ROB_ENTRIES-1:0] mend_q;
  logic [AW-1:0]          areg_q     [ROB_ENTRIES];
  logic [PW-1:0]          preg_q     [ROB_ENTRIES];
  logic [PW-1:0]          old_preg_q [ROB_ENTRIES];

  idx_t head_idx;
  idx_t tail_idx;
  logic alloc_fire;

  assign head_idx = head_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];

  assign flush       = valid_q[head_idx] & ~busy_q[head_idx] & exc_q[head_idx];
  assign alloc_ready = (count_q < ptr_t'(ROB_ENTRIES)) & ~flush;
  assign alloc_fire  = alloc_valid & alloc_ready;
  assign alloc_idx   = tail_idx;
  assign count       = count_q;
  assign irq_ok      = (count_q == '0) | last_mend_q;

  // mbegin is kept per entry for debug visibility; nothing downstream consumes it yet.
  logic unused_mbegin;
  assign unused_mbegin = ^mbegin_q;

  // Writeback decode: same-tag hits on several ports OR their exception flags.
  logic [ROB_ENTRIES-1:0] wb_hit;
  logic [ROB_ENTRIES-1:0] wb_exc_set;

  always_comb begin
    wb_hit     = '0;
    wb_exc_set = '0;
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      idx_t wb_tag;
      wb_tag = wb_idx[p*IW +: IW];
      if (wb_valid[p] && valid_q[wb_tag]) begin
        wb_hit[wb_tag]     = 1'b1;
        wb_exc_set[wb_tag] = wb_exc_set[wb_tag] | wb_exc[p];
      end
    end
  end

  // Commit lanes: a lane retires only if every older lane also retires.
  idx_t [COMMIT_WIDTH-1:0] lane_idx;
  ptr_t                    ncommit;
  logic                    last_mend_d;
  logic                    chain;

  always_comb begin
    chain            = ~flush;
    ncommit          = '0;
    last_mend_d      = last_mend_q;
    lane_idx         = '0;
    commit_valid     = '0;
    commit_has_dest  = '0;
    commit_areg      = '0;
    commit_preg      = '0;
    commit_free_preg = '0;
    for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
      lane_idx[k] = head_idx + idx_t'(k);
      chain = chain & (ptr_t'(k) < count_q) & valid_q[lane_idx[k]] &
              ~busy_q[lane_idx[k]] & ~exc_q[lane_idx[k]];
      commit_valid[k] = chain;
      if (chain) begin
        ncommit                       = ncommit + ptr_t'(1);
        last_mend_d                   = mend_q[lane_idx[k]];
        commit_has_dest[k]            = has_dest_q[lane_idx[k]];
        commit_areg[k*AW +: AW]       = areg_q[lane_idx[k]];
        commit_preg[k*PW +: PW]       = preg_q[lane_idx[k]];
        commit_free_preg[k*PW +: PW]  = old_preg_q[lane_idx[k]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= '0;
      busy_q      <= '0;
      exc_q       <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      last_mend_q <= 1'b1;
    end else if (flush) begin
      // Writebacks and allocation in the flush cycle are dropped with everything else.
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      last_mend_q <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < ROB_ENTRIES; i++) begin
        if (wb_hit[i]) begin
          busy_q[i] <= 1'b0;
          exc_q[i]  <= wb_exc_set[i];
        end
      end
      for (int unsigned k = 0; k < COMMIT_WIDTH; k++) begin
        if (commit_valid[k]) begin
          valid_q[lane_idx[k]] <= 1'b0;
        end
      end
      // The tail slot is never a retiring slot: allocation is blocked when full.
      if (alloc_fire) begin
        valid_q[tail_idx] <= 1'b1;
        busy_q[tail_idx]  <= 1'b1;
        exc_q[tail_idx]   <= 1'b0;
        tail_q            <= tail_q + ptr_t'(1);
      end
      head_q  <= head_q + ncommit;
      count_q <= count_q + ptr_t'(alloc_fire) - ncommit;
      if (ncommit != '0) begin
        last_mend_q <= last_mend_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      has_dest_q[tail_idx] <= alloc_has_dest;
      mbegin_q[tail_idx]   <= alloc_mbegin;
      mend_q[tail_idx]     <= alloc_mend;
      areg_q[tail_idx]     <= alloc_areg;
      preg_q[tail_idx]     <= alloc_preg;
      old_preg_q[tail_idx] <= alloc_old_preg;
    end
  end

  // Occupancy must always equal the wrap-aware pointer distance.
  a_count_matches_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
    count_q == (tail_q - head_q));

  a_no_commit_on_flush: assert property (@(posedge clk) disable iff (!rst_n)
    !(flush && (commit_valid != '0)));

endmodule
